// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scanner.
package seg_pkg;

    // Upper bound on the number of digits a scanner instance may drive.
    localparam int MAX_DIGITS = 16;

    // All segments off (active-low gfedcba).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Anode enables are active-low.
    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;

    typedef logic [3:0] nibble_t;

    // Nibble array sized for the largest bank; instances use the low NUM_DIGITS entries.
    typedef nibble_t [MAX_DIGITS-1:0] nibble_arr_t;

    typedef enum logic {
        PH_DEAD,
        PH_DRIVE
    } slot_phase_t;

endpackage

// File: rtl/binary_to_7seg.sv
// Hex nibble to active-low seven-segment pattern (gfedcba).
module binary_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] bin_i,
    output logic [6:0] seg_o
);

    // Pure lookup table; one instance serves every digit.
    always_comb begin
        seg_o = SEG_BLANK;
        case (bin_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_timer.sv
// Slot/digit counters for the display scanner. Outputs describe the
// counter state being entered on the next edge so the caller can register
// its outputs in step with the counters.
module seg_scan_timer #(
    parameter  int NUM_DIGITS  = 8,
    parameter  int REFRESH_DIV = 50000,
    parameter  int DEAD_CYCLES = 500,
    localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    output logic             slot_dead_o,
    output logic [IDX_W-1:0] digit_idx_o,
    output logic             frame_wrap_o
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] DEAD_END  = TICK_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wrap;

    // Next counter values; disabled scanning parks both counters at zero.
    always_comb begin
        tick_d = tick_q;
        idx_d  = idx_q;
        wrap   = 1'b0;
        if (!enable_i) begin
            tick_d = '0;
            idx_d  = '0;
        end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            tick_d = tick_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q <= '0;
            idx_q  <= '0;
        end else begin
            tick_q <= tick_d;
            idx_q  <= idx_d;
        end
    end

    assign slot_dead_o  = (tick_d < DEAD_END);
    assign digit_idx_o  = idx_d;
    assign frame_wrap_o = wrap;

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with dead time
// between digits and frame-aligned double-buffered display updates.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_an,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic             slot_dead;
    logic [IDX_W-1:0] scan_idx;
    logic             frame_wrap;

    nibble_t [NUM_DIGITS-1:0] active_q, active_d;
    nibble_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                     pending_q, pending_d;

    nibble_t                 cur_nibble;
    logic [6:0]              dec_seg;
    slot_phase_t             phase;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_timer (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .slot_dead_o (slot_dead),
        .digit_idx_o (scan_idx),
        .frame_wrap_o(frame_wrap)
    );

    // Shadow capture and frame-aligned transfer. Accept and apply never
    // coincide: accepting needs pending clear, applying needs it set.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (pending_q && (frame_wrap || !enable)) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (load_valid && !pending_q) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end
    end

    assign load_ready = ~pending_q;

    // Single shared decoder; the digit being entered selects its nibble.
    assign cur_nibble = active_q[scan_idx];

    binary_to_7seg u_dec (
        .bin_i(cur_nibble),
        .seg_o(dec_seg)
    );

    // Output patterns for the slot phase entered on the next edge.
    always_comb begin
        phase = (slot_dead || !enable) ? PH_DEAD : PH_DRIVE;
        an_d  = {NUM_DIGITS{AN_OFF}};
        seg_d = SEG_BLANK;
        if (phase == PH_DRIVE && !blank_mask[scan_idx]) begin
            an_d[scan_idx] = AN_ON;
            seg_d          = dec_seg;
        end
    end

    // Display buffers, handshake flag and registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= {NUM_DIGITS{AN_OFF}};
            frame_tick_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_wrap;
        end
    end

    assign seg_out    = seg_q;
    assign digit_an   = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (4 digits, 8-cycle slots,
// 2 dead cycles). Expected pin states come from a cycle-position model.
module tb_seg_display_scanner;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = ND * RD;

    localparam logic [6:0] HEX_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = '0;
    logic [3:0]  blank_mask = '0;
    logic [6:0]  seg_out;
    logic [3:0]  digit_an;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pos      = 0;   // cycles since scanning (re)started
    logic [15:0] disp     = '0;  // value the display should be showing

    seg_display_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .blank_mask(blank_mask),
        .seg_out   (seg_out),
        .digit_an  (digit_an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, pos=%0d", pos);
        $fatal(1, "watchdog");
    end

    function automatic exp_t expect_at(int unsigned p, logic [15:0] act, logic [3:0] mask);
        exp_t        e;
        int unsigned ph;
        int unsigned slot;
        ph     = p % RD;
        slot   = (p / RD) % ND;
        e.ft   = (p % FRAME == 0) && (p != 0);
        e.an   = 4'b1111;
        e.seg  = 7'h7F;
        if (ph >= DC && !mask[slot]) begin
            e.an[slot] = 1'b0;
            e.seg      = HEX_LUT[act[slot*4 +: 4]];
        end
        return e;
    endfunction

    function automatic int unsigned next_pos();
        return (rst || !enable) ? 0 : pos + 1;
    endfunction

    task automatic tick();
        int unsigned np;
        np = next_pos();
        @(posedge clk);
        #1;
        pos = np;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable     = 1'b1;
        load_valid = 1'b0;
        blank_mask = '0;
        sb.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        pos  = 0;
        disp = '0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_data  = 16'hAAAA;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        n_checks++;
        if (digit_an !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_an: got %b expected 1111", digit_an);
        end
        n_checks++;
        if (seg_out !== 7'h7F) begin
            n_fail++;
            $display("FAIL reset_seg: got %h expected 7f", seg_out);
        end
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", load_ready);
        end
        n_checks++;
        if (frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ft: got %b expected 0", frame_tick);
        end
    endtask

    task automatic test_idle_scan();
        exp_t e;
        do_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL idle_scan pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
        end
    endtask

    task automatic test_load_idle();
        exp_t e;
        do_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 5) begin
                n_checks++;
                if (load_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_idle_ready_pre: got %b expected 1", load_ready);
                end
                load_valid = 1'b1;
                load_data  = 16'h12AF;
            end
            if (k == 6) load_valid = 1'b0;
            if (k == FRAME - 1) disp = 16'h12AF;
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL load_idle pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
            if (pos == 6 || pos == FRAME) begin
                n_checks++;
                if (load_ready !== (pos == FRAME)) begin
                    n_fail++;
                    $display("FAIL load_idle_ready pos=%0d: got %b expected %b",
                             pos, load_ready, (pos == FRAME));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic exp_ready;
        do_reset();
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (k == 10) begin
                load_valid = 1'b1;
                load_data  = 16'h3456;
            end
            if (k == 11) load_data = 16'h789B;
            if (k == 33) load_valid = 1'b0;
            if (k == FRAME - 1) disp = 16'h3456;
            if (k == 2 * FRAME - 1) disp = 16'h789B;
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL back_to_back pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
            exp_ready = !((pos >= 11 && pos <= FRAME - 1) || (pos >= FRAME + 1 && pos <= 2 * FRAME - 1));
            n_checks++;
            if (load_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL back_to_back_ready pos=%0d: got %b expected %b", pos, load_ready, exp_ready);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        exp_t e;
        logic exp_ready;
        do_reset();
        for (int k = 0; k < 3 * FRAME; k++) begin
            if (k == FRAME - 1) begin
                load_valid = 1'b1;
                load_data  = 16'hC0DE;
            end
            if (k == FRAME) load_valid = 1'b0;
            if (k == 2 * FRAME - 1) disp = 16'hC0DE;
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL load_on_wrap pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
            exp_ready = !(pos >= FRAME && pos <= 2 * FRAME - 1);
            n_checks++;
            if (load_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL load_on_wrap_ready pos=%0d: got %b expected %b", pos, load_ready, exp_ready);
            end
        end
    endtask

    task automatic test_blank_mask();
        exp_t e;
        do_reset();
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k == 0) begin
                load_valid = 1'b1;
                load_data  = 16'h5A3C;
            end
            if (k == 1) load_valid = 1'b0;
            if (k == FRAME - 1) disp = 16'h5A3C;
            if (k == FRAME + 2 * RD + 3) blank_mask = 4'b0100;
            if (k == FRAME + 2 * RD + 6) blank_mask = 4'b0000;
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL blank_mask pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
        end
    endtask

    task automatic test_enable();
        exp_t e;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            if (k == 3) begin
                load_valid = 1'b1;
                load_data  = 16'h9876;
            end
            if (k == 4) load_valid = 1'b0;
            if (k == 12) begin
                enable = 1'b0;
                disp   = 16'h9876;
            end
            if (k == 20) enable = 1'b1;
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL enable k=%0d pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         k, pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
            if (k == 3 || k == 12) begin
                n_checks++;
                if (load_ready !== (k == 12)) begin
                    n_fail++;
                    $display("FAIL enable_ready k=%0d: got %b expected %b", k, load_ready, (k == 12));
                end
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        exp_t e;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k == 2) begin
                load_valid = 1'b1;
                load_data  = 16'hFFFF;
            end
            if (k == 3) load_valid = 1'b0;
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL rst_mid_pre pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({digit_an, seg_out} !== {4'b1111, 7'h7F}) begin
            n_fail++;
            $display("FAIL rst_mid_dark: got an=%b seg=%h expected an=1111 seg=7f", digit_an, seg_out);
        end
        n_checks++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready: got %b expected 1", load_ready);
        end
        n_checks++;
        if (frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ft: got %b expected 0", frame_tick);
        end
        #1;
        rst  = 1'b0;
        pos  = 0;
        disp = '0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            sb.push_back(expect_at(next_pos(), disp, blank_mask));
            tick();
            e = sb.pop_front();
            n_checks++;
            if ({digit_an, seg_out, frame_tick} !== e) begin
                n_fail++;
                $display("FAIL rst_mid_post pos=%0d: got an=%b seg=%h ft=%b, expected an=%b seg=%h ft=%b",
                         pos, digit_an, seg_out, frame_tick, e.an, e.seg, e.ft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_load_idle();
        test_back_to_back();
        test_load_on_wrap();
        test_blank_mask();
        test_enable();
        test_reset_mid_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

- Time-multiplexed controller for a bank of common-anode seven-segment digits.
- Scans NUM_DIGITS digits through one shared hex decoder and inserts dead time between digits to prevent ghosting.
- Accepts new display values through a valid/ready handshake. New values are applied only at frame boundaries, so the display never tears.
- Sits between the processor's display/debug register and the board's segment and anode pins.

## Interface
- NUM_DIGITS, 8: number of digits scanned; 2..16.
- REFRESH_DIV, 50000: clock cycles per digit slot; must exceed DEAD_CYCLES + 1.
- DEAD_CYCLES, 500: cycles at the start of each slot with all anodes off.
- clk  in  1  single clock for all logic.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  scan enable; low = display dark, counters held at 0.
- load_valid  in  1  load_data is offered.
- load_ready  out  1  shadow register free; a load is accepted when load_valid & load_ready.
- load_data  in  4*NUM_DIGITS  hex nibbles; digit i = bits [4i+3:4i].
- blank_mask  in  NUM_DIGITS  1 = keep digit i dark; sampled live, not shadowed.
- seg_out  out  7  active-low segments, gfedcba order.
- digit_an  out  NUM_DIGITS  active-low anode enables; at most one bit low at a time.
- frame_tick  out  1  one-cycle pulse on the frame-wrap edge.

## Operation
- Internal state:
  - tick_cnt: 0..REFRESH_DIV-1.
  - digit_idx: 0..NUM_DIGITS-1.
  - active: display register, 4*NUM_DIGITS bits.
  - shadow: same width as active.
  - pending: 1 bit.
- Slot phases:
  - DEAD while tick_cnt < DEAD_CYCLES: digit_an all 1s, seg_out = 7'h7F.
  - DRIVE otherwise: digit_an[digit_idx] = 0 unless blank_mask[digit_idx] = 1; seg_out = decode(active nibble digit_idx). A masked digit outputs 7'h7F.
- Counter advance: tick_cnt increments each cycle. At REFRESH_DIV-1 it wraps to 0 and digit_idx increments. digit_idx wraps from NUM_DIGITS-1 to 0; that edge is the frame wrap.
- Handshake:
  - load_ready = ~pending, combinational.
  - An accepted load writes shadow and sets pending.
  - On the frame-wrap edge, if pending: active <= shadow, pending <= 0.
  - A load accepted on the frame-wrap edge itself, with pending = 0, lands in shadow and is applied at the next wrap.
- enable = 0:
  - Counters are forced to 0; outputs are dark (as in DEAD).
  - frame_tick stays 0.
  - If pending, active <= shadow on the next edge and pending clears, since there is no visible tearing.
- enable 0->1: scanning restarts at digit 0 with a full DEAD phase.
- Reset, including mid-frame or mid-handshake:
  - tick_cnt = 0, digit_idx = 0, active = 0, shadow = 0, pending = 0.
  - Outputs: digit_an all 1s, seg_out = 7'h7F, load_ready = 1, frame_tick = 0.
  - A load in flight is discarded.

## Timing
- seg_out, digit_an and frame_tick are registered. Each is computed from the next-state counters, so it changes on the same edge the counters enter a phase. No output glitch between the anode and segment changes.
- Slot = REFRESH_DIV cycles: DEAD_CYCLES dark, then REFRESH_DIV-DEAD_CYCLES driven. Frame = NUM_DIGITS*REFRESH_DIV cycles.
- Load-to-display latency: from acceptance to the next frame-wrap edge, at most one frame plus one cycle. The first driven slot showing the new data is digit 0, DEAD_CYCLES cycles after the wrap.
- load_ready falls the cycle after acceptance and rises the cycle after the applying wrap.
- blank_mask change: visible at the next edge within a DRIVE phase.
- Counter widths are $clog2 of each range; tick_cnt never exceeds REFRESH_DIV-1.

## Structure
- Package seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - Active-low polarity constants.
  - A typedef for the nibble array (logic [NUM_DIGITS-1:0][3:0]).
- Sub-module seg_scan_timer contains tick_cnt and digit_idx. It outputs slot_dead, digit_idx and frame_wrap.
- Exactly one instance of the existing binary_to_7seg decoder (active-low gfedcba) is driven by the nibble mux. Do not duplicate the LUT.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
- Reset release, no load: every slot shows digit_an=4'b1111 for 2 cycles, then the slot's digit low with seg_out=7'h40 (digit 0); frame_tick every 32 cycles.
- Load 16'h12AF while idle, then scan one frame. Driven slots:
  - digit_an=4'b1110 with seg_out=7'h0E (F).
  - digit_an=4'b1101 with seg_out=7'h08 (A).
  - digit_an=4'b1011 with seg_out=7'h24 (2).
  - digit_an=4'b0111 with seg_out=7'h79 (1).
- Load issued mid-frame with a second load held valid: second load stalls (load_ready=0) until the cycle after the wrap. No frame mixes old and new nibbles.
- Load accepted exactly on the frame_tick edge: the data appears only after the following wrap, 32 cycles later.
- blank_mask=4'b0100 during DRIVE of digit 2: next edge digit_an=4'b1111, seg_out=7'h7F.
- Reset asserted mid-DRIVE with pending=1: outputs are immediately dark and load_ready=1. After release, all digits show 7'h40.
